// File: rtl/dfh_walker_pkg.sv
// Shared types for the DFH chain walker: header layout, FSM states and
// termination codes.
package dfh_walker_pkg;

   localparam int DFH_EOL_BIT = 40;
   localparam int DFH_OFS_LSB = 16;
   localparam int DFH_OFS_W   = 24;

   typedef struct packed {
      logic [3:0]                feat_type;
      logic [58-DFH_EOL_BIT:0]   rsvd_hi;
      logic                      eol;
      logic [DFH_OFS_W-1:0]      nxt_dfh_offset;
      logic [DFH_OFS_LSB-13:0]   rsvd_lo;
      logic [11:0]               feat_id;
   } t_dfh;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_EMIT = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } t_walk_state;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_RSP       = 3'd1,
      ERR_TIMEOUT   = 3'd2,
      ERR_ZERO_OFS  = 3'd3,
      ERR_MAX_FEAT  = 3'd4,
      ERR_ADDR_WRAP = 3'd5
   } t_walk_err;

endpackage

// File: rtl/dfh_walker.sv
// Walks a DFH linked list through a single-outstanding CSR read port and
// streams each header out; ends on EOL or with an error code.
module dfh_walker
   import dfh_walker_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int MAX_FEAT    = 32,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = $clog2(MAX_FEAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code,
   output logic [CNT_W-1:0]  feat_count,
   output logic              rd_req_valid,
   input  logic              rd_req_ready,
   output logic [ADDR_W-1:0] rd_req_addr,
   input  logic              rd_rsp_valid,
   input  logic [63:0]       rd_rsp_data,
   input  logic              rd_rsp_err,
   output logic              feat_valid,
   input  logic              feat_ready,
   output logic [ADDR_W-1:0] feat_addr,
   output logic [63:0]       feat_dfh,
   output logic [CNT_W-1:0]  feat_idx
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int SUM_W = ADDR_W + 1;
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FEAT);

   t_walk_state          state_r;
   logic [ADDR_W-1:0]    cur_addr_r;
   logic [TMR_W-1:0]     timer_r;
   logic [TMR_W-1:0]     timer_inc_s;
   logic [CNT_W-1:0]     cnt_inc_s;
   logic [DFH_OFS_W-1:0] offset_s;
   logic [SUM_W-1:0]     nxt_sum_s;
   t_walk_err            emit_err_s;

   // Next-header arithmetic and the post-handshake error priority (after EOL)
   always_comb begin
      timer_inc_s = (timer_r == TMR_MAX) ? timer_r : timer_r + TMR_W'(1);
      cnt_inc_s   = feat_count + CNT_W'(1);
      offset_s    = feat_dfh[DFH_OFS_LSB +: DFH_OFS_W];
      nxt_sum_s   = {1'b0, cur_addr_r} + SUM_W'(offset_s);
      if (offset_s == '0) begin
         emit_err_s = ERR_ZERO_OFS;
      end else if (cnt_inc_s == CNT_MAX) begin
         emit_err_s = ERR_MAX_FEAT;
      end else if (nxt_sum_s[ADDR_W]) begin
         emit_err_s = ERR_ADDR_WRAP;
      end else begin
         emit_err_s = ERR_NONE;
      end
   end

   // Walk FSM; every output is a register updated on the state transition
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cur_addr_r   <= '0;
         timer_r      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= ERR_NONE;
         feat_count   <= '0;
         feat_idx     <= '0;
         feat_addr    <= '0;
         feat_dfh     <= '0;
         feat_valid   <= 1'b0;
         rd_req_valid <= 1'b0;
         rd_req_addr  <= '0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  cur_addr_r   <= base_addr;
                  rd_req_addr  <= base_addr;
                  rd_req_valid <= 1'b1;
                  feat_count   <= '0;
                  err          <= 1'b0;
                  err_code     <= ERR_NONE;
                  busy         <= 1'b1;
                  state_r      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (rd_req_ready) begin
                  rd_req_valid <= 1'b0;
                  timer_r      <= '0;
                  state_r      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A response in the expiry cycle still wins over the timeout
               if (rd_rsp_valid) begin
                  if (rd_rsp_err) begin
                     err      <= 1'b1;
                     err_code <= ERR_RSP;
                     done     <= 1'b1;
                     state_r  <= ST_ERR;
                  end else begin
                     feat_dfh   <= rd_rsp_data;
                     feat_addr  <= cur_addr_r;
                     feat_idx   <= feat_count;
                     feat_valid <= 1'b1;
                     state_r    <= ST_EMIT;
                  end
               end else if (timer_inc_s == TMR_MAX) begin
                  err      <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  done     <= 1'b1;
                  state_r  <= ST_ERR;
               end else begin
                  timer_r <= timer_inc_s;
               end
            end
            ST_EMIT: begin
               if (feat_ready) begin
                  feat_valid <= 1'b0;
                  feat_count <= cnt_inc_s;
                  if (feat_dfh[DFH_EOL_BIT]) begin
                     done    <= 1'b1;
                     state_r <= ST_DONE;
                  end else if (emit_err_s != ERR_NONE) begin
                     err      <= 1'b1;
                     err_code <= emit_err_s;
                     done     <= 1'b1;
                     state_r  <= ST_ERR;
                  end else begin
                     cur_addr_r   <= nxt_sum_s[ADDR_W-1:0];
                     rd_req_addr  <= nxt_sum_s[ADDR_W-1:0];
                     rd_req_valid <= 1'b1;
                     state_r      <= ST_REQ;
                  end
               end
            end
            ST_DONE, ST_ERR: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy         <= 1'b0;
               rd_req_valid <= 1'b0;
               feat_valid   <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dfh_walker.sv
// Scoreboard bench for dfh_walker: a CSR memory model answers reads, expected
// beats are queued when a chain is built and popped on each feature handshake.
module tb_dfh_walker;
   import dfh_walker_pkg::*;

   localparam int ADDR_W      = 32;
   localparam int MAX_FEAT    = 4;
   localparam int TIMEOUT_CYC = 16;
   localparam int CNT_W       = $clog2(MAX_FEAT + 1);

   typedef struct {
      logic [31:0] addr;
      logic [63:0] dfh;
      int          idx;
   } t_beat;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              busy, done, err;
   logic [2:0]        err_code;
   logic [CNT_W-1:0]  feat_count, feat_idx;
   logic              rd_req_valid;
   logic              rd_req_ready = 1'b1;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_rsp_valid = 1'b0;
   logic [63:0]       rd_rsp_data = '0;
   logic              rd_rsp_err = 1'b0;
   logic              feat_valid;
   logic              feat_ready = 1'b1;
   logic [ADDR_W-1:0] feat_addr;
   logic [63:0]       feat_dfh;

   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          t_start = 0;
   int          walk_id = 0;
   t_beat       exp_q[$];
   logic [63:0] mem [logic [31:0]];

   // responder / sink controls
   bit          silent = 1'b0;
   bit          err_en = 1'b0;
   logic [31:0] err_addr = '0;
   int          rsp_lat = 0;
   bit          ready_rand = 1'b0;
   int          inject_req = 0;
   int          inject_done = 0;
   int          stall_idx = 0;
   int          stall_len = 0;

   dfh_walker #(
      .ADDR_W(ADDR_W), .MAX_FEAT(MAX_FEAT), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .feat_count(feat_count),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
      .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_addr(feat_addr),
      .feat_dfh(feat_dfh), .feat_idx(feat_idx)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [63:0] mk_dfh(input logic eol, input logic [23:0] ofs, input logic [11:0] id);
      t_dfh h;
      h.feat_type      = 4'h3;
      h.rsvd_hi        = {7'h55, id};
      h.eol            = eol;
      h.nxt_dfh_offset = ofs;
      h.rsvd_lo        = 4'hA;
      h.feat_id        = id;
      return h;
   endfunction

   task automatic put_hdr(input logic [31:0] addr, input logic eol, input logic [23:0] ofs,
                          input logic [11:0] id, input int idx);
      t_beat b;
      mem[addr] = mk_dfh(eol, ofs, id);
      if (idx >= 0) begin
         b.addr = addr;
         b.dfh  = mem[addr];
         b.idx  = idx;
         exp_q.push_back(b);
      end
   endtask

   task automatic responder_loop();
      bit          pend = 1'b0;
      int          dly = 0;
      logic [31:0] paddr = '0;
      forever begin
         @(negedge clk);
         rd_rsp_valid = 1'b0;
         rd_rsp_err   = 1'b0;
         rd_rsp_data  = '0;
         if (rst) pend = 1'b0;
         if (inject_req != inject_done) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = 64'hDEAD_BEEF_0000_0001;
            inject_done++;
         end else if (pend) begin
            if (dly == 0) begin
               pend = 1'b0;
               if (!silent) begin
                  rd_rsp_valid = 1'b1;
                  rd_rsp_err   = err_en && (paddr == err_addr);
                  rd_rsp_data  = mem.exists(paddr) ? mem[paddr] : 64'h0;
               end
            end else begin
               dly--;
            end
         end
         rd_req_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (rd_req_valid && rd_req_ready && !rst) begin
            pend  = 1'b1;
            dly   = rsp_lat;
            paddr = rd_req_addr;
         end
      end
   endtask

   task automatic sink_loop();
      int    stall_left = 0;
      int    stalled_walk = -1;
      t_beat e;
      forever begin
         @(negedge clk);
         feat_ready = 1'b1;
         if (feat_valid && !rst) begin
            if (stall_len > 0 && int'(feat_idx) == stall_idx && stalled_walk != walk_id) begin
               stalled_walk = walk_id;
               stall_left   = stall_len;
            end
            if (stall_left > 0) begin
               stall_left--;
               feat_ready = 1'b0;
               chk("stall_beat_pending", 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) begin
                  chk("stall_addr", 64'(feat_addr), 64'(exp_q[0].addr));
                  chk("stall_dfh", feat_dfh, exp_q[0].dfh);
                  chk("stall_idx", 64'(feat_idx), 64'(exp_q[0].idx));
               end
               chk("stall_no_req", 64'(rd_req_valid), 64'd0);
            end else begin
               chk("beat_pending", 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("beat_addr", 64'(feat_addr), 64'(e.addr));
                  chk("beat_dfh", feat_dfh, e.dfh);
                  chk("beat_idx", 64'(feat_idx), 64'(e.idx));
               end
            end
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_err_code"}, 64'(err_code), 64'd0);
      chk({tag, "_feat_count"}, 64'(feat_count), 64'd0);
      chk({tag, "_feat_idx"}, 64'(feat_idx), 64'd0);
      chk({tag, "_feat_addr"}, 64'(feat_addr), 64'd0);
      chk({tag, "_feat_dfh"}, feat_dfh, 64'd0);
      chk({tag, "_feat_valid"}, 64'(feat_valid), 64'd0);
      chk({tag, "_rd_req_valid"}, 64'(rd_req_valid), 64'd0);
      chk({tag, "_rd_req_addr"}, 64'(rd_req_addr), 64'd0);
   endtask

   task automatic run_walk(input logic [31:0] base, input logic [2:0] code, input int cnt,
                           input bit poke, input int exp_dur);
      int n = 0;
      walk_id++;
      @(negedge clk);
      start     = 1'b1;
      base_addr = base;
      t_start   = cyc;
      @(negedge clk);
      start     = 1'b0;
      base_addr = 32'h5A5A_5A5A;
      chk("req_latency", 64'(rd_req_valid), 64'd1);
      chk("req_addr", 64'(rd_req_addr), 64'(base));
      chk("err_cleared", 64'(err), 64'd0);
      chk("count_cleared", 64'(feat_count), 64'd0);
      chk("busy_walk", 64'(busy), 64'd1);
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
         if (poke && n == 4) begin
            start     = 1'b1;
            base_addr = 32'hABC0_0000;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("done_seen", 64'(done), 64'd1);
      if (exp_dur > 0) chk("walk_cycles", 64'(cyc - t_start), 64'(exp_dur));
      chk("err_flag", 64'(err), 64'(code != 3'd0));
      chk("err_code", 64'(err_code), 64'(code));
      chk("feat_count", 64'(feat_count), 64'(cnt));
      chk("busy_at_done", 64'(busy), 64'd1);
      chk("beats_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
      exp_q.delete();
      mem.delete();
   endtask

   task automatic build_chain3();
      put_hdr(32'h0000_0000, 1'b0, 24'h001000, 12'h001, 0);
      put_hdr(32'h0000_1000, 1'b0, 24'h002000, 12'h002, 1);
      put_hdr(32'h0000_3000, 1'b1, 24'h000000, 12'h003, 2);
   endtask

   initial begin
      fork
         responder_loop();
         sink_loop();
      join_none

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("rst0");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // three-header chain, zero-latency responses: 1 + 3 cycles per header
      build_chain3();
      run_walk(32'h0, 3'd0, 3, 1'b0, 10);

      // same chain with back-pressure on beat 1 and a slower, bursty read port
      build_chain3();
      stall_idx  = 1;
      stall_len  = 10;
      rsp_lat    = 2;
      ready_rand = 1'b1;
      run_walk(32'h0, 3'd0, 3, 1'b0, 0);
      stall_len  = 0;
      rsp_lat    = 0;
      ready_rand = 1'b0;

      // error response on the second read
      put_hdr(32'h0000_0100, 1'b0, 24'h000040, 12'h011, 0);
      put_hdr(32'h0000_0140, 1'b1, 24'h000040, 12'h012, -1);
      err_en   = 1'b1;
      err_addr = 32'h0000_0140;
      run_walk(32'h100, 3'd1, 1, 1'b0, 0);
      err_en = 1'b0;
      repeat (5) @(negedge clk);
      chk("err_held", 64'(err), 64'd1);
      chk("err_code_held", 64'(err_code), 64'd1);

      // no response at all: timeout 16 cycles after acceptance
      silent = 1'b1;
      run_walk(32'h200, 3'd2, 0, 1'b0, 18);
      silent = 1'b0;
      inject_req++;
      repeat (3) @(negedge clk);
      chk("late_rsp_no_beat", 64'(feat_valid), 64'd0);
      chk("late_rsp_idle", 64'(busy), 64'd0);

      // zero offset without EOL
      put_hdr(32'h0000_0400, 1'b0, 24'h000000, 12'h021, 0);
      run_walk(32'h400, 3'd3, 1, 1'b0, 0);

      // six-entry chain stops at MAX_FEAT; a start pulse mid-walk is ignored
      for (int i = 0; i < 6; i++) begin
         put_hdr(32'h0001_0000 + 32'(i * 32'h100), (i == 5), 24'h000100,
                 12'(12'h030 + 12'(i)), (i < MAX_FEAT) ? i : -1);
      end
      run_walk(32'h0001_0000, 3'd4, 4, 1'b1, 0);

      // next address carries out of the address space
      put_hdr(32'hFFFF_F000, 1'b0, 24'h002000, 12'h041, 0);
      run_walk(32'hFFFF_F000, 3'd5, 1, 1'b0, 0);

      // reset while waiting for a response; response arrives after release
      silent = 1'b1;
      walk_id++;
      @(negedge clk);
      start     = 1'b1;
      base_addr = 32'h0000_0500;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("wait_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      silent = 1'b0;
      inject_req++;
      repeat (2) @(negedge clk);
      check_reset_vals("post_rst");

      // the walker still runs normally afterwards
      build_chain3();
      run_walk(32'h0, 3'd0, 3, 1'b0, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dfh_walker.md
# dfh_walker

Hardware Device Feature Header (DFH) chain walker. On a start pulse it follows the DFH linked list from a programmable base address through a single-outstanding CSR read port. Each header is emitted on a back-pressurable feature stream. The walk terminates on EOL or on a detected error with a status code. It sits beside the host/SoC CSR fabric and serves in-fabric discovery and the DFH self-check used by unit tests.

## Interface
Parameters:
- `ADDR_W`, 32, CSR byte-address width.
- `MAX_FEAT`, 32, maximum headers walked before the overflow error.
- `TIMEOUT_CYC`, 1024, cycles allowed from request acceptance to response.
- `CNT_W`, `$clog2(MAX_FEAT+1)`, feature-count width (derived).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: begin walk; sampled only in IDLE.
- `base_addr` in ADDR_W: first DFH address; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: walk ended in error; held until the next accepted `start`.
- `err_code` out 3: 0 none, 1 RSP_ERR, 2 TIMEOUT, 3 ZERO_OFS, 4 MAX_FEAT, 5 ADDR_WRAP; held like `err`.
- `feat_count` out CNT_W: headers emitted in the current or last walk.
- `rd_req_valid`/`rd_req_ready` out/in 1: read request handshake.
- `rd_req_addr` out ADDR_W: read address.
- `rd_rsp_valid` in 1: read response; the walker is always ready.
- `rd_rsp_data` in 64: read data.
- `rd_rsp_err` in 1: response error.
- `feat_valid`/`feat_ready` out/in 1: feature stream handshake.
- `feat_addr` out ADDR_W: address of the emitted DFH.
- `feat_dfh` out 64: raw DFH word.
- `feat_idx` out CNT_W: zero-based index of the emitted DFH.

## Operation
- DFH fields: `feat_type` [63:60], `eol` [40], `nxt_dfh_offset` [39:16], `feat_id` [11:0]. All other bits pass through unchecked.
- FSM states: IDLE, REQ, WAIT, EMIT, DONE, ERR.
- IDLE:
  - On `start`: `cur_addr` ← `base_addr`; clear `feat_count`, `err`, `err_code`.
  - Go to REQ.
- REQ:
  - `rd_req_valid`=1 with `rd_req_addr`=`cur_addr`, held stable until `rd_req_ready`.
  - On handshake: go to WAIT and clear the timer.
- WAIT:
  - On `rd_rsp_valid` with `rd_rsp_err`: go to ERR with code 1.
  - On `rd_rsp_valid` without `rd_rsp_err`: latch the data into `feat_dfh`; go to EMIT.
  - When the timer reaches `TIMEOUT_CYC` with no response: go to ERR with code 2.
  - A response and timer expiry in the same cycle: the response wins.
- EMIT: `feat_valid`=1, with `feat_addr`/`feat_dfh`/`feat_idx` held stable until `feat_ready`. On handshake `feat_count`++, then the first matching check applies:
  - `eol`=1: go to DONE.
  - `nxt_dfh_offset`==0: go to ERR with code 3.
  - new `feat_count`==`MAX_FEAT`: go to ERR with code 4.
  - `cur_addr`+offset (zero-extended, ADDR_W+1 bits) carries out: go to ERR with code 5.
  - Otherwise: `cur_addr` ← `cur_addr`+offset; go to REQ.
- DONE: `done`=1 for one cycle; go to IDLE.
- ERR: `done`=1 and `err`=1 with the code set; go to IDLE.
- `start` while busy is ignored.
- `rd_rsp_valid` outside WAIT is ignored and dropped. This covers late responses after reset or timeout.
- Reset in any state:
  - FSM goes to IDLE.
  - `busy`, `done`, `err`, `rd_req_valid`, `feat_valid` = 0.
  - `err_code`, `feat_count`, `feat_idx`, `feat_addr`, `feat_dfh`, `rd_req_addr`, `cur_addr` = 0.
  - Any in-flight read is abandoned.

## Timing
- All outputs are registered; `rd_req_valid` and `feat_valid` are driven from FSM state.
- `start` → `rd_req_valid`: 1 cycle.
- Response → `feat_valid`: 1 cycle.
- `feat_ready` handshake → next `rd_req_valid`: 1 cycle.
- Minimum per-header cost, with ready and zero-latency response: 3 cycles (REQ, WAIT, EMIT).
- Last handshake → `done`: 1 cycle. `busy` falls the cycle after `done`.
- Timer is `$clog2(TIMEOUT_CYC+1)` bits, saturating, and counts only in WAIT.
- Exactly one read is outstanding at a time.

## Structure
- `dfh_walker_pkg` holds:
  - `t_dfh` packed struct (field layout above);
  - `t_walk_state` enum;
  - `t_walk_err` enum (codes 0–5);
  - `DFH_EOL_BIT` and offset-field localparams.
- Single module, no sub-modules. Timer, address adder and FSM are inline.

## Test plan
- Chain with base 0x0, offsets 0x1000 then 0x2000, EOL on the third header → three beats at 0x0/0x1000/0x3000 with idx 0/1/2, then `done`, `feat_count`=3, `err`=0.
- `feat_ready` held low 10 cycles during beat 1 → beat data stable, no new `rd_req_valid`; the walk completes identically afterwards.
- Second response returned with `rd_rsp_err`=1 → `err_code`=1, `feat_count`=1. Timeout set to 16 with no response → `done` 16 cycles after acceptance with `err_code`=2.
- Header with eol=0 and offset 0 → `err_code`=3. `MAX_FEAT`=4 on a 6-entry chain → 4 beats then `err_code`=4. Base 0xFFFF_F000 with offset 0x2000 → `err_code`=5.
- `rst` asserted in WAIT, response delivered 2 cycles after release → response ignored, all outputs at reset values; `start` asserted while busy → ignored.
